// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: PC sequencing, valid/ready instruction fetch with skid buffer, redirect drain, IF/ID register.
// Revision 1.0
module fetch_stage #(
   parameter logic [63:0] PC_RESET = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [63:0] branch_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [63:0] if_id_pc,
   output logic [10:0] opcode_bits
);

   localparam logic [63:0] C_PC_RESET = {PC_RESET[63:2], 2'b00};
   localparam logic [63:0] C_ALIGN    = ~64'd3;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] drain_addr_q, drain_addr_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [63:0] skid_pc_q, skid_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] ifpc_q, ifpc_d;

   logic [63:0] w_target;
   logic [63:0] w_pc_inc;

   assign w_target = branch_target & C_ALIGN;
   assign w_pc_inc = pc_q + 64'd4;

   // The request is withdrawn combinationally while reset is asserted.
   assign imem_req    = !rst && (state_q != S_HOLD);
   assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign if_id_valid = valid_q;
   assign if_id_instr = instr_q;
   assign if_id_pc    = ifpc_q;
   assign opcode_bits = instr_q[31:21];

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      ifpc_d       = ifpc_q;
      case (state_q)
         S_FETCH: begin
            if (pc_src) begin
               pc_d    = w_target;
               valid_d = 1'b0;
               if (!imem_ready) begin
                  drain_addr_d = pc_q;
                  state_d      = S_DRAIN;
               end
            end else if (imem_ready) begin
               pc_d = w_pc_inc;
               if (!stall) begin
                  instr_d = imem_data;
                  ifpc_d  = pc_q;
                  valid_d = 1'b1;
               end else begin
                  skid_instr_d = imem_data;
                  skid_pc_d    = pc_q;
                  state_d      = S_HOLD;
               end
            end else if (!stall) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (pc_src) begin
               pc_d    = w_target;
               valid_d = 1'b0;
               state_d = S_FETCH;
            end else if (!stall) begin
               instr_d = skid_instr_q;
               ifpc_d  = skid_pc_q;
               valid_d = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            valid_d = 1'b0;
            if (pc_src) begin
               pc_d = w_target;
            end
            // Once the abandoned beat completes there is nothing left to drain.
            if (imem_ready) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= C_PC_RESET;
         drain_addr_q <= 64'd0;
         skid_instr_q <= 32'd0;
         skid_pc_q    <= 64'd0;
         valid_q      <= 1'b0;
         instr_q      <= 32'd0;
         ifpc_q       <= 64'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         ifpc_q       <= ifpc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: directed checks of fetch_stage with a memory returning addr[31:0] as data.
// Revision 1.0
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_data;
   logic        stall;
   logic        pc_src;
   logic [63:0] branch_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [63:0] if_id_pc;
   logic [10:0] opcode_bits;

   int tests = 0;
   int fails = 0;

   fetch_stage #(.PC_RESET(64'h100)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_data     (imem_data),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .if_id_valid   (if_id_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc      (if_id_pc),
      .opcode_bits   (opcode_bits)
   );

   assign imem_data = imem_addr[31:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [63:0] pc);
      chk({tag, "_valid"}, {63'd0, if_id_valid}, {63'd0, v});
      chk({tag, "_pc"}, if_id_pc, pc);
      chk({tag, "_instr"}, {32'd0, if_id_instr}, {32'd0, pc[31:0]});
   endtask

   initial begin
      rst = 1'b1;
      imem_ready = 1'b0;
      stall = 1'b0;
      pc_src = 1'b0;
      branch_target = 64'd0;
      #2;
      chk("rst_req", {63'd0, imem_req}, 64'd0);
      chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
      chk("rst_instr", {32'd0, if_id_instr}, 64'd0);
      chk("rst_pc", if_id_pc, 64'd0);
      chk("rst_opc", {53'd0, opcode_bits}, 64'd0);
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rel_req", {63'd0, imem_req}, 64'd1);
      chk("rel_addr", imem_addr, 64'h100);

      // zero-wait stream
      imem_ready = 1'b1;
      tick(); chk_ifid("zw0", 1'b1, 64'h100);
      chk("zw0_opc", {53'd0, opcode_bits}, 64'd0);
      tick(); chk_ifid("zw1", 1'b1, 64'h104);
      tick(); chk_ifid("zw2", 1'b1, 64'h108);
      chk("zw2_addr", imem_addr, 64'h10C);

      // two-cycle latency
      imem_ready = 1'b0;
      tick(); chk_ifid("lat_bub0", 1'b0, 64'h108);
      chk("lat_addr0", imem_addr, 64'h10C);
      chk("lat_req0", {63'd0, imem_req}, 64'd1);
      imem_ready = 1'b1;
      tick(); chk_ifid("lat_v0", 1'b1, 64'h10C);
      imem_ready = 1'b0;
      tick(); chk_ifid("lat_bub1", 1'b0, 64'h10C);
      chk("lat_addr1", imem_addr, 64'h110);
      imem_ready = 1'b1;
      tick(); chk_ifid("lat_v1", 1'b1, 64'h110);

      // three-cycle stall while the next beat completes
      tick(); chk_ifid("pre_stall", 1'b1, 64'h114);
      stall = 1'b1;
      tick(); chk_ifid("stall0", 1'b1, 64'h114);
      chk("stall0_req", {63'd0, imem_req}, 64'd0);
      tick(); chk_ifid("stall1", 1'b1, 64'h114);
      chk("stall1_req", {63'd0, imem_req}, 64'd0);
      tick(); chk_ifid("stall2", 1'b1, 64'h114);
      stall = 1'b0;
      tick(); chk_ifid("unstall", 1'b1, 64'h118);
      chk("unstall_req", {63'd0, imem_req}, 64'd1);
      chk("unstall_addr", imem_addr, 64'h11C);
      tick(); chk_ifid("resume", 1'b1, 64'h11C);

      // redirect during zero-wait fetch, unaligned target
      pc_src = 1'b1;
      branch_target = 64'h203;
      tick(); chk("br_valid", {63'd0, if_id_valid}, 64'd0);
      chk("br_addr", imem_addr, 64'h200);
      pc_src = 1'b0;
      tick(); chk_ifid("br_tgt", 1'b1, 64'h200);

      // redirect during an outstanding request to 0x110
      pc_src = 1'b1;
      branch_target = 64'h110;
      tick(); chk("r110_valid", {63'd0, if_id_valid}, 64'd0);
      pc_src = 1'b0;
      imem_ready = 1'b0;
      tick(); chk("wait_addr0", imem_addr, 64'h110);
      pc_src = 1'b1;
      branch_target = 64'h400;
      tick(); chk("drain_addr0", imem_addr, 64'h110);
      chk("drain_req0", {63'd0, imem_req}, 64'd1);
      chk("drain_valid0", {63'd0, if_id_valid}, 64'd0);
      pc_src = 1'b0;
      tick(); chk("drain_addr1", imem_addr, 64'h110);
      imem_ready = 1'b1;
      tick(); chk_ifid("drain_done", 1'b0, 64'h200);
      chk("drain_new_addr", imem_addr, 64'h400);
      tick(); chk_ifid("tgt400", 1'b1, 64'h400);

      // redirect and stall together: redirect wins, no HOLD
      stall = 1'b1;
      pc_src = 1'b1;
      branch_target = 64'h300;
      tick(); chk("bs_valid", {63'd0, if_id_valid}, 64'd0);
      chk("bs_req", {63'd0, imem_req}, 64'd1);
      chk("bs_addr", imem_addr, 64'h300);

      // enter DRAIN, then reset mid-drain
      stall = 1'b0;
      pc_src = 1'b0;
      imem_ready = 1'b0;
      tick();
      pc_src = 1'b1;
      branch_target = 64'h500;
      tick(); chk("d2_addr", imem_addr, 64'h300);
      pc_src = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_req", {63'd0, imem_req}, 64'd0);
      chk("mrst_valid", {63'd0, if_id_valid}, 64'd0);
      chk("mrst_instr", {32'd0, if_id_instr}, 64'd0);
      chk("mrst_pc", if_id_pc, 64'd0);
      chk("mrst_opc", {53'd0, opcode_bits}, 64'd0);
      chk("mrst_addr", imem_addr, 64'h100);
      tick();
      rst = 1'b0;
      #1;
      chk("mrel_req", {63'd0, imem_req}, 64'd1);
      chk("mrel_addr", imem_addr, 64'h100);
      imem_ready = 1'b1;
      tick(); chk_ifid("mrel_first", 1'b1, 64'h100);

      // PC wrap at the top of the address space
      pc_src = 1'b1;
      branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
      tick(); chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      pc_src = 1'b0;
      tick(); chk_ifid("wrap", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_opc", {53'd0, opcode_bits}, 64'h7FF);
      chk("wrap_addr1", imem_addr, 64'd0);
      tick(); chk_ifid("wrap0", 1'b1, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
